// File: rtl/pkt_steer_pkg.sv
// Shared constants and encodings for the packet steering block.
// Header values are stored in tdata byte order, not in network order.
package pkt_steer_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4        = 16'h0008;
  localparam logic [7:0]  IPPROT_UDP           = 8'h11;
  localparam logic [15:0] DEFAULT_CONTROL_PORT = 16'hf2f1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_SEND1 = 3'd2,
    ST_FWD   = 3'd3,
    ST_DROP  = 3'd4
  } state_t;

  typedef enum logic {
    DEST_DATA = 1'b0,
    DEST_CTRL = 1'b1
  } dest_t;

endpackage

// File: rtl/pkt_steer_axis_out_reg.sv
// Single-entry AXI-Stream register stage. The payload is cleared whenever
// the stage is empty, so an idle channel always presents zeros.
module pkt_steer_axis_out_reg #(
  parameter int DW = 256,
  parameter int TW = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DW+DW/8+TW:0]  in_beat,
  output logic                 can_accept,
  output logic [DW-1:0]        m_tdata,
  output logic [DW/8-1:0]      m_tkeep,
  output logic [TW-1:0]        m_tuser,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready
);

  logic [DW+DW/8+TW:0] beat_q;
  logic                valid_q;

  assign can_accept = ~valid_q | m_tready;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      beat_q  <= in_beat;
    end else if (m_tready) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end
  end

  assign m_tvalid = valid_q;
  assign {m_tlast, m_tuser, m_tkeep, m_tdata} = beat_q;

endmodule

// File: rtl/pkt_steer.sv
// Ingress steering: classifies each packet from its first two beats and sends
// it to the data pipeline, the control channel, or drops it.
module pkt_steer
  import pkt_steer_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_BITS      = 4,
  parameter int ETH_TYPE_LSB         = 128,
  parameter int IP_PROT_LSB          = 216,
  parameter int UDP_DPORT_LSB        = 64,
  parameter int STAT_WIDTH           = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]      ctrl_m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    ctrl_m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     ctrl_m_axis_tuser,
  output logic                                ctrl_m_axis_tvalid,
  output logic                                ctrl_m_axis_tlast,
  input  logic                                ctrl_m_axis_tready,
  input  logic [15:0]                         cfg_ctrl_port,
  input  logic                                cfg_drop_non_udp,
  input  logic                                stat_clear,
  output logic [STAT_WIDTH-1:0]               stat_data_pkts,
  output logic [STAT_WIDTH-1:0]               stat_ctrl_pkts,
  output logic [STAT_WIDTH-1:0]               stat_drop_pkts
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int TW    = C_S_AXIS_TUSER_WIDTH;
  localparam int BW    = DW + DW/8 + TW + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] NEARLY_FULL = (FIFO_DEPTH_BITS+1)'(DEPTH - 1);

  // Input FIFO: fall-through, head visible combinationally
  logic [BW-1:0]              fifo_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   fifo_cnt;
  logic                       wr_en, pop, fifo_empty;
  logic [BW-1:0]              head;

  assign s_axis_tready = ~reset & (fifo_cnt < NEARLY_FULL);
  assign wr_en         = s_axis_tvalid & s_axis_tready;
  assign fifo_empty    = (fifo_cnt == '0);
  assign head          = fifo_mem[rd_ptr];

  // NOTE: storage array is deliberately not reset; occupancy is tracked by
  // the pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
      if (pop)   rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (FIFO_DEPTH_BITS+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (FIFO_DEPTH_BITS+1)'(1);
        default: ;
      endcase
    end
  end

  state_t        state, state_nxt;
  dest_t         dest, dest_nxt;
  logic [BW-1:0] hold_beat;
  logic          hold_en, fwd_hold, fwd_head, drop_done;
  logic          data_can, ctrl_can, dest_ready;
  logic          head_last, hold_last, head_is_udp, head_is_ctrl;
  logic [BW-1:0] out_beat;

  assign head_last    = head[BW-1];
  assign hold_last    = hold_beat[BW-1];
  assign head_is_udp  = (head[ETH_TYPE_LSB +: 16] == ETH_TYPE_IPV4) &&
                        (head[IP_PROT_LSB +: 8] == IPPROT_UDP);
  assign head_is_ctrl = (head[UDP_DPORT_LSB +: 16] == cfg_ctrl_port);
  assign dest_ready   = (dest == DEST_CTRL) ? ctrl_can : data_can;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) dest <= DEST_DATA;
    else       dest <= dest_nxt;
    if (hold_en) hold_beat <= head;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    dest_nxt  = dest;
    case (state)
      ST_IDLE: if (!fifo_empty) begin
        if (head_is_udp) begin
          if (head_last) begin
            dest_nxt  = DEST_DATA;
            state_nxt = ST_SEND1;
          end else begin
            state_nxt = ST_HOLD;
          end
        end else if (!cfg_drop_non_udp) begin
          dest_nxt  = DEST_DATA;
          state_nxt = ST_SEND1;
        end else if (!head_last) begin
          state_nxt = ST_DROP;
        end
      end
      ST_HOLD: if (!fifo_empty) begin
        dest_nxt  = head_is_ctrl ? DEST_CTRL : DEST_DATA;
        state_nxt = ST_SEND1;
      end
      ST_SEND1: if (dest_ready) state_nxt = hold_last ? ST_IDLE : ST_FWD;
      ST_FWD:   if (!fifo_empty && dest_ready && head_last) state_nxt = ST_IDLE;
      ST_DROP:  if (!fifo_empty && head_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    hold_en   = 1'b0;
    fwd_hold  = 1'b0;
    fwd_head  = 1'b0;
    drop_done = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        hold_en   = 1'b1;
        drop_done = ~head_is_udp & cfg_drop_non_udp & head_last;
      end
      ST_SEND1: fwd_hold = dest_ready;
      ST_FWD: if (!fifo_empty && dest_ready) begin
        pop      = 1'b1;
        fwd_head = 1'b1;
      end
      ST_DROP: if (!fifo_empty) begin
        pop       = 1'b1;
        drop_done = head_last;
      end
      default: ;
    endcase
  end

  assign out_beat = fwd_hold ? hold_beat : head;

  pkt_steer_axis_out_reg #(.DW(DW), .TW(TW)) u_data_out (
    .clk(clk), .reset(reset),
    .load((fwd_hold | fwd_head) & (dest == DEST_DATA)),
    .in_beat(out_beat), .can_accept(data_can),
    .m_tdata(m_axis_tdata), .m_tkeep(m_axis_tkeep), .m_tuser(m_axis_tuser),
    .m_tvalid(m_axis_tvalid), .m_tlast(m_axis_tlast), .m_tready(m_axis_tready)
  );

  pkt_steer_axis_out_reg #(.DW(DW), .TW(TW)) u_ctrl_out (
    .clk(clk), .reset(reset),
    .load((fwd_hold | fwd_head) & (dest == DEST_CTRL)),
    .in_beat(out_beat), .can_accept(ctrl_can),
    .m_tdata(ctrl_m_axis_tdata), .m_tkeep(ctrl_m_axis_tkeep), .m_tuser(ctrl_m_axis_tuser),
    .m_tvalid(ctrl_m_axis_tvalid), .m_tlast(ctrl_m_axis_tlast), .m_tready(ctrl_m_axis_tready)
  );

  // Packet counters saturate; a clear in the same cycle beats an increment
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      stat_data_pkts <= '0;
      stat_ctrl_pkts <= '0;
      stat_drop_pkts <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast && stat_data_pkts != '1)
        stat_data_pkts <= stat_data_pkts + STAT_WIDTH'(1);
      if (ctrl_m_axis_tvalid && ctrl_m_axis_tready && ctrl_m_axis_tlast && stat_ctrl_pkts != '1)
        stat_ctrl_pkts <= stat_ctrl_pkts + STAT_WIDTH'(1);
      if (drop_done && stat_drop_pkts != '1)
        stat_drop_pkts <= stat_drop_pkts + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pkt_steer.sv
// Randomised bench for pkt_steer: packets are generated with a known
// destination, and every output beat and counter is checked against that.
module tb_pkt_steer;
  import pkt_steer_pkg::*;

  localparam int DW = 256;
  localparam int KW = DW/8;
  localparam int TW = 128;
  localparam int K_UDP = 0, K_ARP = 1, K_TCP = 2;
  localparam int RDY_ON = 0, RDY_RAND = 1, RDY_OFF = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [TW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct packed {
    beat_t b;
    logic  sop;
  } item_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [TW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata, ctrl_m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep, ctrl_m_axis_tkeep;
  logic [TW-1:0] m_axis_tuser, ctrl_m_axis_tuser;
  logic          m_axis_tvalid, m_axis_tlast, ctrl_m_axis_tvalid, ctrl_m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          ctrl_m_axis_tready = 1'b1;
  logic [15:0]   cfg_ctrl_port = 16'h0;
  logic          cfg_drop_non_udp = 1'b0;
  logic          stat_clear = 1'b0;
  logic [31:0]   stat_data_pkts, stat_ctrl_pkts, stat_drop_pkts;

  pkt_steer dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .ctrl_m_axis_tdata(ctrl_m_axis_tdata), .ctrl_m_axis_tkeep(ctrl_m_axis_tkeep),
    .ctrl_m_axis_tuser(ctrl_m_axis_tuser), .ctrl_m_axis_tvalid(ctrl_m_axis_tvalid),
    .ctrl_m_axis_tlast(ctrl_m_axis_tlast), .ctrl_m_axis_tready(ctrl_m_axis_tready),
    .cfg_ctrl_port(cfg_ctrl_port), .cfg_drop_non_udp(cfg_drop_non_udp),
    .stat_clear(stat_clear), .stat_data_pkts(stat_data_pkts),
    .stat_ctrl_pkts(stat_ctrl_pkts), .stat_drop_pkts(stat_drop_pkts)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: pending input beats, expected output beats per
  // channel, and expected packet counts (0 data, 1 ctrl, 2 drop).
  item_t in_q[$];
  beat_t exp_data[$];
  beat_t exp_ctrl[$];
  int    exp_cnt[3] = '{0, 0, 0};

  int cyc = 0;
  int sop_cyc = 0;
  int gap_pct = 0;
  int m_mode = RDY_ON;
  int c_mode = RDY_ON;
  logic fire = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Input driver: presents in_q head, holds it stable until accepted
  always @(negedge clk) begin
    if (reset) begin
      s_axis_tvalid = 1'b0;
      fire = 1'b0;
    end else begin
      if (fire && in_q.size() > 0) begin
        if (in_q[0].sop) sop_cyc = cyc;
        void'(in_q.pop_front());
      end
      if (!(s_axis_tvalid && !fire)) begin
        if (in_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
          s_axis_tvalid = 1'b1;
          {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = in_q[0].b;
        end else begin
          s_axis_tvalid = 1'b0;
        end
      end
      fire = s_axis_tvalid & s_axis_tready;
    end
  end

  logic  stall[2] = '{1'b0, 1'b0};
  logic  prev_vld[2] = '{1'b0, 1'b0};
  beat_t prev[2];
  int    rise_cyc[2] = '{0, 0};

  function automatic logic pick(input int mode);
    if (mode == RDY_ON) return 1'b1;
    if (mode == RDY_OFF) return 1'b0;
    return ($urandom_range(3) != 0);
  endfunction

  task automatic mon_chan(input int ch, input logic vld, input logic rdy, input beat_t got);
    beat_t exp;
    string nm;
    nm = (ch == 0) ? "m" : "ctrl";
    if (stall[ch]) begin
      check({nm, "_hold_valid"}, vld, 1'b1);
      check({nm, "_hold_beat"}, got, prev[ch]);
    end
    if (!vld) check({nm, "_idle_zero"}, got, '0);
    if (vld && !prev_vld[ch]) rise_cyc[ch] = cyc;
    if (vld && rdy) begin
      if ((ch == 0 && exp_data.size() == 0) || (ch == 1 && exp_ctrl.size() == 0)) begin
        check({nm, "_spurious_beat"}, vld & rdy, 1'b0);
      end else begin
        exp = (ch == 0) ? exp_data.pop_front() : exp_ctrl.pop_front();
        check({nm, "_beat"}, got, exp);
      end
    end
    stall[ch]    = vld & ~rdy;
    prev[ch]     = got;
    prev_vld[ch] = vld;
  endtask

  // Output monitors: choose tready, then check the beat that will handshake
  always @(negedge clk) begin
    if (reset) begin
      stall    = '{1'b0, 1'b0};
      prev_vld = '{1'b0, 1'b0};
    end else begin
      m_axis_tready      = pick(m_mode);
      ctrl_m_axis_tready = pick(c_mode);
      mon_chan(0, m_axis_tvalid, m_axis_tready,
               {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast});
      mon_chan(1, ctrl_m_axis_tvalid, ctrl_m_axis_tready,
               {ctrl_m_axis_tdata, ctrl_m_axis_tkeep, ctrl_m_axis_tuser, ctrl_m_axis_tlast});
    end
  end

  // Build a packet, decide its fate from the header rules and current config
  task automatic send_pkt(input int kind, input int nbeats, input logic [15:0] dport);
    item_t it;
    int    dest;
    if (kind != K_UDP) dest = cfg_drop_non_udp ? 2 : 0;
    else               dest = (nbeats > 1 && dport == cfg_ctrl_port) ? 1 : 0;
    exp_cnt[dest]++;
    for (int i = 0; i < nbeats; i++) begin
      for (int w = 0; w < DW/32; w++) it.b.data[32*w +: 32] = $urandom();
      it.b.keep = $urandom();
      for (int w = 0; w < TW/32; w++) it.b.user[32*w +: 32] = $urandom();
      it.b.last = (i == nbeats - 1);
      it.sop    = (i == 0);
      if (i == 0) begin
        it.b.data[128 +: 16] = (kind == K_ARP) ? 16'h0608 : 16'h0008;
        if (kind == K_UDP) it.b.data[216 +: 8] = 8'h11;
        if (kind == K_TCP) it.b.data[216 +: 8] = 8'h06;
      end
      if (i == 1) it.b.data[64 +: 16] = dport;
      in_q.push_back(it);
      if (dest == 0) exp_data.push_back(it.b);
      if (dest == 1) exp_ctrl.push_back(it.b);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((in_q.size() != 0 || exp_data.size() != 0 || exp_ctrl.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_done"}, n < 5000, 1'b1);
    repeat (40) @(negedge clk);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_stat_data"}, stat_data_pkts, exp_cnt[0]);
    check({tag, "_stat_ctrl"}, stat_ctrl_pkts, exp_cnt[1]);
    check({tag, "_stat_drop"}, stat_drop_pkts, exp_cnt[2]);
  endtask

  task automatic wait_valid(input string tag, input int ch);
    int n;
    n = 0;
    while (((ch == 0) ? !m_axis_tvalid : !ctrl_m_axis_tvalid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_seen"}, n < 200, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_ctrl_port = DEFAULT_CONTROL_PORT;
    repeat (3) @(negedge clk);
    check("reset_s_tready", s_axis_tready, 1'b0);
    check("reset_m_tvalid", m_axis_tvalid, 1'b0);
    check("reset_ctrl_tvalid", ctrl_m_axis_tvalid, 1'b0);
    check_stats("reset");
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_s_tready", s_axis_tready, 1'b1);

    send_pkt(K_UDP, 3, 16'h1234);
    drain("udp_data");
    check_stats("udp_data");

    c_mode = RDY_OFF;
    send_pkt(K_UDP, 2, 16'hf2f1);
    wait_valid("ctrl_stall", 1);
    repeat (5) @(negedge clk);
    check("ctrl_stall_valid", ctrl_m_axis_tvalid, 1'b1);
    check("ctrl_stall_m_idle", m_axis_tvalid, 1'b0);
    c_mode = RDY_ON;
    drain("udp_ctrl");
    check_stats("udp_ctrl");

    cfg_drop_non_udp = 1'b1;
    send_pkt(K_ARP, 3, 16'h0);
    send_pkt(K_UDP, 2, 16'h1234);
    drain("arp_drop");
    check_stats("arp_drop");

    cfg_drop_non_udp = 1'b0;
    send_pkt(K_ARP, 3, 16'h0);
    drain("arp_pass");
    check_stats("arp_pass");

    send_pkt(K_UDP, 1, 16'h0);
    cfg_drop_non_udp = 1'b1;
    send_pkt(K_ARP, 1, 16'h0);
    send_pkt(K_UDP, 2, 16'h5678);
    drain("single_beat");
    check_stats("single_beat");

    send_pkt(K_UDP, 2, 16'h1234);
    drain("latency");
    check("latency_cycles", rise_cyc[0] - sop_cyc, 3);

    m_mode = RDY_OFF;
    for (int p = 0; p < 6; p++) send_pkt(K_UDP, 5, 16'h1234);
    repeat (40) @(negedge clk);
    check("bp_s_tready_low", s_axis_tready, 1'b0);
    check("bp_m_valid_held", m_axis_tvalid, 1'b1);
    m_mode = RDY_RAND;
    drain("backpressure");
    check_stats("backpressure");

    gap_pct = 30;
    for (int r = 0; r < 8; r++) begin
      cfg_drop_non_udp = 1'($urandom_range(1));
      cfg_ctrl_port    = $urandom_range(1) ? 16'hf2f1 : 16'($urandom());
      m_mode = RDY_RAND;
      c_mode = RDY_RAND;
      for (int p = 0; p < 10; p++)
        send_pkt($urandom_range(2), $urandom_range(5, 1),
                 $urandom_range(1) ? cfg_ctrl_port : 16'($urandom()));
      drain("random");
      check_stats("random");
    end

    m_mode = RDY_OFF;
    c_mode = RDY_ON;
    send_pkt(K_UDP, 5, 16'h1234);
    wait_valid("mid_reset", 0);
    @(negedge clk);
    reset = 1'b1;
    in_q.delete();
    exp_data.delete();
    exp_ctrl.delete();
    exp_cnt = '{0, 0, 0};
    @(negedge clk);
    check("mid_reset_m_tvalid", m_axis_tvalid, 1'b0);
    check("mid_reset_ctrl_tvalid", ctrl_m_axis_tvalid, 1'b0);
    check("mid_reset_s_tready", s_axis_tready, 1'b0);
    check_stats("mid_reset");
    m_mode = RDY_ON;
    @(negedge clk);
    reset = 1'b0;
    cfg_drop_non_udp = 1'b0;
    send_pkt(K_UDP, 2, 16'h1234);
    send_pkt(K_TCP, 3, 16'h0);
    drain("after_reset");
    check_stats("after_reset");

    m_mode = RDY_OFF;
    send_pkt(K_UDP, 1, 16'h0);
    wait_valid("clear_race", 0);
    @(negedge clk); #1;
    m_mode = RDY_ON;
    @(negedge clk); #1;
    stat_clear = 1'b1;
    exp_cnt = '{0, 0, 0};
    @(negedge clk); #1;
    stat_clear = 1'b0;
    drain("clear_race");
    check_stats("clear_race");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pkt_steer.md
Name: pkt_steer

Overview:
- Parametrised successor to the ingress packet filter. Classifies each AXI-Stream packet from its first two beats and steers it to one of three destinations: data pipeline, control (reconfiguration) channel, or drop.
- Adds back-pressure on the control channel, runtime-configurable control UDP port, a selectable non-UDP policy, correct handling of single-beat packets, and saturating per-destination packet counters.
- Sits between the MAC-side AXIS input and the RMT parser / config-packet consumer.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width; must be ≥256.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- FIFO_DEPTH_BITS, 4, log2 depth of the input FIFO.
- ETH_TYPE_LSB, 128, bit offset of ethertype in beat 0.
- IP_PROT_LSB, 216, bit offset of IP protocol in beat 0.
- UDP_DPORT_LSB, 64, bit offset of UDP destination port in beat 1.
- STAT_WIDTH, 32, width of each packet counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  DW/DW/8/TW/1/1  input stream
- s_axis_tready  out  1  high when the input FIFO is not nearly full
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  DW/DW/8/TW/1/1  data-path stream
- m_axis_tready  in  1  data-path back-pressure
- ctrl_m_axis_tdata/tkeep/tuser/tvalid/tlast  out  DW/DW/8/TW/1/1  control stream
- ctrl_m_axis_tready  in  1  control back-pressure
- cfg_ctrl_port  in  16  control UDP port in tdata byte order (nominal 16'hf2f1)
- cfg_drop_non_udp  in  1  1 = drop non-IPv4/UDP packets; 0 = send them to the data path
- stat_clear  in  1  synchronous clear of all counters
- stat_data_pkts, stat_ctrl_pkts, stat_drop_pkts  out  STAT_WIDTH each  saturating packet counters

Behaviour:
- Input: fall-through FIFO, write enable = s_axis_tvalid & s_axis_tready. All classification reads the FIFO head.
- Outputs: one registered stage per channel.
  - A beat loads only when the stage is empty or its tready is high.
  - tvalid/tdata stay stable while tvalid=1 and tready=0.
  - The channel not selected holds tvalid=0; its data is don't-care but driven to 0.
- Reset: every output and counter is 0; s_axis_tready=0 while reset is high; FIFO flushed; state returns to IDLE.
  - Reset mid-packet discards the partial packet. Downstream may see a truncated packet without tlast; this is accepted.
- FSM:
  - IDLE, FIFO non-empty: pop beat 0 into the hold register.
    - Passes (ethertype==16'h0008 && proto==8'h11) and not tlast: go to HOLD.
    - Passes and tlast: dest=DATA, go to SEND1.
    - Fails and cfg_drop_non_udp=0: dest=DATA, go to SEND1.
    - Fails and cfg_drop_non_udp=1: if tlast, count the drop and stay in IDLE; otherwise go to DROP.
  - HOLD, FIFO non-empty: peek beat 1 without popping. dest=CTRL if beat1[UDP_DPORT_LSB+:16]==cfg_ctrl_port, else DATA. Go to SEND1.
  - SEND1: when the dest output stage can accept, load the hold register. If the held beat is tlast, go to IDLE; otherwise go to FWD.
  - FWD: on FIFO non-empty and the dest stage able to accept, pop and load. On tlast, go to IDLE.
  - DROP: pop every cycle the FIFO is non-empty. On tlast, count the drop and go to IDLE.
- Config is sampled only at the classification point. Changes mid-packet do not affect the packet in flight.
- The non-selected channel's tready is ignored. A stalled destination blocks only through the FIFO, which eventually deasserts s_axis_tready. No beat is ever lost or duplicated.
- Latency: a beat-0 at the FIFO head in IDLE (beat 1 present, tready high) reaches its output tvalid 3 cycles later. The following beats stream at 1 beat/cycle.
- Counters:
  - data/ctrl increment on the output handshake (tvalid & tready) of a tlast beat.
  - drop increments when a dropped tlast is popped.
  - Saturate at all-ones.
  - stat_clear wins over a same-cycle increment.

Decomposition:
- Shared header pkt_filter_defs.vh holds ETH_TYPE_IPV4 (16'h0008), IPPROT_UDP (8'h11), DEFAULT_CONTROL_PORT (16'hf2f1), the FSM state encodings and the DEST_DATA/DEST_CTRL codes.
- One sub-module, axis_out_reg (a single-entry AXIS register stage with tready), instantiated once per output channel.
- Reuses the existing fallthrough_small_fifo.

Test Plan:
- Three-beat UDP packet with dport 16'h1234 and cfg_ctrl_port=16'hf2f1 → 3 beats on m_axis in order, ctrl tvalid never high, stat_data_pkts=1.
- Two-beat UDP packet with dport 16'hf2f1 and ctrl_m_axis_tready low for 5 cycles → ctrl tvalid held with stable data for 5 cycles, then both beats delivered; m_axis tvalid stays 0; stat_ctrl_pkts=1.
- ARP packet (ethertype 16'h0608) with cfg_drop_non_udp=1, followed by a UDP data packet → no output for the ARP, stat_drop_pkts=1; the UDP packet is delivered intact.
- Same ARP packet with cfg_drop_non_udp=0 → delivered on m_axis, stat_data_pkts=1.
- Single-beat UDP packet with tlast on beat 0 → delivered on m_axis with tlast=1, FSM back to IDLE, no hang.
- Back-to-back packets with m_axis_tready=0 for 40 cycles → s_axis_tready falls within FIFO depth, no data loss; reset asserted mid-packet → all tvalid=0 the next cycle and counters=0.
